// File: rtl/pipelined_subtractor_16bit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pipelined_subtractor_16bit_pkg
// Purpose : Shared types and constants for the two-stage 16-bit subtractor.
//           Holds the operand width and half width, the saturation limits and
//           the packed stage-1 pipeline register layout.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package pipelined_subtractor_16bit_pkg;

  localparam int SUB_WIDTH = 16;
  localparam int SUB_HALF  = SUB_WIDTH / 2;

  localparam logic [SUB_WIDTH-1:0] MAX_POS = 16'h7FFF;
  localparam logic [SUB_WIDTH-1:0] MAX_NEG = 16'h8000;

  // Everything stage 2 needs: the finished low byte, the inter-byte carry,
  // the untouched high halves (subtrahend already inverted) and both sign
  // bits for the overflow test.
  typedef struct packed {
    logic [SUB_HALF-1:0] lo;
    logic                c_mid;
    logic [SUB_HALF-1:0] a_hi;
    logic [SUB_HALF-1:0] nb_hi;
    logic                a_msb;
    logic                b_msb;
  } s1_reg_t;

  // Saturation target follows the sign of the minuend.
  function automatic logic [SUB_WIDTH-1:0] sat_value(input logic a_msb);
    return a_msb ? MAX_NEG : MAX_POS;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipelined_subtractor_16bit_sub_slice_8bit.sv
`default_nettype none
// ============================================================================
// Module  : sub_slice_8bit
// Purpose : Combinational W-bit carry-lookahead computation of x + ~y + cin.
//           Used once per pipeline stage of the subtractor.
// Ports   : i_x    - first operand
//           i_y    - operand to be inverted
//           i_cin  - carry in
//           o_sum  - W-bit sum
//           o_cout - carry out
// Revision: 1.0 - initial release
// ============================================================================
module sub_slice_8bit #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_x,
  input  logic [W-1:0] i_y,
  input  logic         i_cin,
  output logic [W-1:0] o_sum,
  output logic         o_cout
);

  logic [W-1:0] w_g;
  logic [W-1:0] w_p;
  logic [W:0]   w_c;

  assign w_g = i_x & ~i_y;
  assign w_p = i_x ^ ~i_y;

  // Each carry is the flat OR of every generate term that can reach it,
  // masked by the running product of intervening propagates.
  always_comb begin
    logic acc;
    logic pp;
    w_c    = '0;
    w_c[0] = i_cin;
    for (int i = 0; i < W; i++) begin
      acc = w_g[i];
      pp  = w_p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (pp & w_g[j]);
        pp  = pp & w_p[j];
      end
      acc      = acc | (pp & i_cin);
      w_c[i+1] = acc;
    end
  end

  assign o_sum  = w_p ^ w_c[W-1:0];
  assign o_cout = w_c[W];

endmodule
`default_nettype wire

// File: rtl/pipelined_subtractor_16bit.sv
`default_nettype none
// ============================================================================
// Module  : pipelined_subtractor_16bit
// Purpose : Two-stage valid/ready pipelined subtractor, d = a - b - bin.
//           Stage 1 resolves the low half, stage 2 the high half plus flags.
//           Optional macro SUB_SATURATE_EN clamps d on signed overflow.
// Ports   : clk, rst_n (async, active-low)
//           in_valid/in_ready   - input handshake, operands a, b, bin
//           out_valid/out_ready - output handshake
//           d    - difference        bout - unsigned borrow out
//           ovf  - signed overflow   zero - d == 0
// Notes   : WIDTH must be even and match the package width.
// Revision: 1.0 - initial release
// ============================================================================
module pipelined_subtractor_16bit
  import pipelined_subtractor_16bit_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int L = WIDTH / 2;

  logic             r_s1_valid;
  s1_reg_t          r_s1;
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_d;
  logic             r_bout;
  logic             r_ovf;
  logic             r_zero;

  logic             w_s2_adv;
  logic [L-1:0]     w_lo;
  logic             w_c_mid;
  s1_reg_t          w_s1_next;
  logic [L-1:0]     w_hi;
  logic             w_c_out;
  logic [WIDTH-1:0] w_raw;
  logic             w_ovf;
  logic [WIDTH-1:0] w_d_next;
  logic             w_zero;

  // Stage 2 may take new data when empty or when its result leaves this
  // cycle; stage 1 may refill whenever it is empty or stage 2 moves.
  assign w_s2_adv = !r_s2_valid || out_ready;
  assign in_ready = !r_s1_valid || w_s2_adv;

  // Stage 1: low half with carry-in = ~bin (subtract as add of complement).
  sub_slice_8bit #(.W(L)) u_slice_lo (
    .i_x    (a[L-1:0]),
    .i_y    (b[L-1:0]),
    .i_cin  (~bin),
    .o_sum  (w_lo),
    .o_cout (w_c_mid)
  );

  assign w_s1_next.lo    = w_lo;
  assign w_s1_next.c_mid = w_c_mid;
  assign w_s1_next.a_hi  = a[WIDTH-1:L];
  assign w_s1_next.nb_hi = ~b[WIDTH-1:L];
  assign w_s1_next.a_msb = a[WIDTH-1];
  assign w_s1_next.b_msb = b[WIDTH-1];

  // Stage 2: the slice re-inverts its y input, so feed it the original
  // high half of b to end up adding nb_hi.
  sub_slice_8bit #(.W(L)) u_slice_hi (
    .i_x    (r_s1.a_hi),
    .i_y    (~r_s1.nb_hi),
    .i_cin  (r_s1.c_mid),
    .o_sum  (w_hi),
    .o_cout (w_c_out)
  );

  assign w_raw = {w_hi, r_s1.lo};
  assign w_ovf = (r_s1.a_msb != r_s1.b_msb) && (w_raw[WIDTH-1] != r_s1.a_msb);

`ifdef SUB_SATURATE_EN
  assign w_d_next = w_ovf ? sat_value(r_s1.a_msb) : w_raw;
`else
  assign w_d_next = w_raw;
`endif

  assign w_zero = (w_d_next == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
      r_s2_valid <= 1'b0;
      r_d        <= '0;
      r_bout     <= 1'b0;
      r_ovf      <= 1'b0;
      r_zero     <= 1'b0;
    end else begin
      if (in_ready) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1 <= w_s1_next;
        end
      end
      // Result registers only load on real data so an empty pipe keeps
      // presenting the last result.
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_d    <= w_d_next;
          r_bout <= ~w_c_out;
          r_ovf  <= w_ovf;
          r_zero <= w_zero;
        end
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign d         = r_d;
  assign bout      = r_bout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_subtractor_16bit.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipelined_subtractor_16bit
// Purpose : Self-checking bench for pipelined_subtractor_16bit. Accepted
//           operands push a reference result to a queue; every output
//           transfer pops and compares. Directed steps cover latency,
//           streaming, back-pressure hold and asynchronous reset.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pipelined_subtractor_16bit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] d;
  logic        bout;
  logic        ovf;
  logic        zero;

  typedef struct packed {
    logic [15:0] d;
    logic        bout;
    logic        ovf;
    logic        zero;
  } exp_t;

  exp_t sb[$];
  int   in_cyc[$];
  int   out_cyc[$];
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t e;

  pipelined_subtractor_16bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .bout      (bout),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [15:0] xa, input logic [15:0] xb,
                                 input logic xbin);
    exp_t        r;
    logic [16:0] full;
    full   = {1'b0, xa} - {1'b0, xb} - {16'b0, xbin};
    r.d    = full[15:0];
    r.bout = full[16];
    r.ovf  = (xa[15] != xb[15]) && (r.d[15] != xa[15]);
`ifdef SUB_SATURATE_EN
    if (r.ovf) r.d = xa[15] ? 16'h8000 : 16'h7FFF;
`endif
    r.zero = (r.d == 16'h0000);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pop and compare on output transfer, push on input transfer.
  always @(negedge clk) begin
    cyc++;
    if (rst_n === 1'b1) begin
      if (out_valid && out_ready) begin
        out_cyc.push_back(cyc);
        check("sb_nonempty", (sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("d", d, e.d);
          check("bout", bout, e.bout);
          check("ovf", ovf, e.ovf);
          check("zero", zero, e.zero);
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(a, b, bin));
        in_cyc.push_back(cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the transfer edge.
  task automatic send(input logic [15:0] xa, input logic [15:0] xb, input logic xbin);
    int k;
    a = xa; b = xb; bin = xbin; in_valid = 1'b1;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    check("send_accept", (k < 50), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) break;
    end
    check("drain", sb.size(), 0);
  endtask

  // Empty pipe, out_ready=1: result must be visible exactly 2 cycles later.
  task automatic lat_check(input logic [15:0] xa, input logic [15:0] xb,
                           input logic xbin, input logic [15:0] xd);
    a = xa; b = xb; bin = xbin; in_valid = 1'b1;
    @(negedge clk);
    check("lat_accept", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_cycle1_valid", out_valid, 0);
    @(negedge clk);
    check("lat_cycle2_valid", out_valid, 1);
    check("lat_d", d, xd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] hold;
    logic        have;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b1;

    // Reset state
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_d", d, 0);
    check("rst_bout", bout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_zero", zero, 0);
    step();
    rst_n = 1'b1;

    // Basic vector with latency
    step();
    lat_check(16'h1234, 16'h0034, 1'b0, 16'h1200);
    drain();

    // Directed arithmetic corners
    step();
    send(16'h0000, 16'h0001, 1'b0);
    send(16'h00FF, 16'h00FF, 1'b0);
    send(16'h8000, 16'h0001, 1'b0);
    send(16'h0000, 16'h0000, 1'b1);
    send(16'h0100, 16'h0001, 1'b0);
    send(16'h7FFF, 16'hFFFF, 1'b0);
    send(16'hABCD, 16'hABCD, 1'b0);
    drain();

    // Back-to-back stream: 8 in, 8 out on consecutive cycles
    in_cyc.delete(); out_cyc.delete();
    step();
    for (int i = 0; i < 8; i++) begin
      a = 16'($urandom()); b = 16'($urandom()); bin = 1'($urandom()); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    drain();
    check("stream_in_count", in_cyc.size(), 8);
    check("stream_out_count", out_cyc.size(), 8);
    if (in_cyc.size() == 8 && out_cyc.size() == 8) begin
      check("stream_latency", out_cyc[0] - in_cyc[0], 2);
      for (int i = 1; i < 8; i++) check("stream_gap", out_cyc[i] - out_cyc[i-1], 1);
    end

    // Back-pressure: out_ready low for 5 cycles, only 2 accepts, d held
    in_cyc.delete(); out_cyc.delete();
    step();
    out_ready = 1'b0;
    have = 1'b0;
    hold = '0;
    a = 16'h4321; b = 16'h1234; bin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid) begin
        if (!have) begin hold = d; have = 1'b1; end
        else check("hold_d", d, hold);
      end
      @(posedge clk);
      #1;
      a = 16'($urandom()); b = 16'($urandom()); bin = 1'($urandom());
    end
    check("stall_accepts", in_cyc.size(), 2);
    check("stall_in_ready", in_ready, 0);
    check("stall_out_valid", out_valid, 1);
    check("stall_no_out", out_cyc.size(), 0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    check("stall_out_count", out_cyc.size(), 2);

    // Asynchronous reset with both stages full
    step();
    out_ready = 1'b0;
    send(16'h1111, 16'h0001, 1'b0);
    send(16'h2222, 16'h0002, 1'b0);
    check("full_out_valid", out_valid, 1);
    check("full_in_ready", in_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_out_valid", out_valid, 0);
    check("async_in_ready", in_ready, 1);
    check("async_d", d, 0);
    sb.delete();
    #3;
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    lat_check(16'h0005, 16'h0003, 1'b0, 16'h0002);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
